// File: rtl/pic_pkg.sv
// Shared encodings and helpers for the 8259A CPU-side bus initiator.
package pic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT_WR = 3'd1,
    ST_READY   = 3'd2,
    ST_ACK1    = 3'd3,
    ST_ACK_GAP = 3'd4,
    ST_ACK2    = 3'd5,
    ST_EOI_WR  = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    STEP_ICW1 = 3'd0,
    STEP_ICW2 = 3'd1,
    STEP_ICW3 = 3'd2,
    STEP_ICW4 = 3'd3,
    STEP_OCW1 = 3'd4
  } init_step_t;

  typedef enum logic [2:0] {
    WC_IDLE  = 3'd0,
    WC_SETUP = 3'd1,
    WC_PULSE = 3'd2,
    WC_HOLD  = 3'd3,
    WC_GAP   = 3'd4
  } wc_state_t;

  localparam int ICW1_SNGL = 1;
  localparam int ICW1_IC4  = 0;
  localparam int ICW4_AEOI = 1;

  localparam logic [7:0] NS_EOI = 8'h20;
  localparam logic [7:0] S_EOI  = 8'h60;

  // OCW2 byte for an EOI command
  function automatic logic [7:0] ocw2_eoi(input logic specific, input logic [2:0] level);
    return specific ? (S_EOI | {5'b00000, level}) : NS_EOI;
  endfunction

  // Next initialization word, skipping ICW3 in single mode and ICW4 when IC4=0
  function automatic init_step_t next_step(input init_step_t cur, input logic sngl, input logic ic4);
    case (cur)
      STEP_ICW1: return STEP_ICW2;
      STEP_ICW2: return sngl ? (ic4 ? STEP_ICW4 : STEP_OCW1) : STEP_ICW3;
      STEP_ICW3: return ic4 ? STEP_ICW4 : STEP_OCW1;
      default:   return STEP_OCW1;
    endcase
  endfunction

endpackage

// File: rtl/pic_cpu_intack_master_bus_write.sv
// One PIC write bus cycle: setup, WR_bar pulse, hold, then idle gap.
module pic_bus_write_cycle
  import pic_pkg::*;
#(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       abort,
  input  logic       start,
  input  logic       a0,
  input  logic [7:0] data,
  output logic       CS_bar,
  output logic       WR_bar,
  output logic       A0,
  output logic [7:0] D_out,
  output logic       D_oe,
  output logic       done
);

  wc_state_t  r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic       w_load;
  logic       r_a0;
  logic [7:0] r_data;

  // Phase register plus the address/data latched when a cycle is accepted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= WC_IDLE;
      r_cnt   <= '0;
      r_a0    <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load) begin
        r_a0   <= a0;
        r_data <= data;
      end
    end
  end

  // Phase sequencing; abort drops straight back to idle with strobes released
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    done        = 1'b0;
    case (r_state)
      WC_IDLE: if (start) begin
        w_state_nxt = WC_SETUP;
        w_load      = 1'b1;
      end
      WC_SETUP: begin
        w_state_nxt = WC_PULSE;
        w_cnt_nxt   = '0;
      end
      WC_PULSE: if (r_cnt == 8'(PULSE_W - 1)) begin
        w_state_nxt = WC_HOLD;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = r_cnt + 8'd1;
      end
      WC_HOLD: begin
        w_state_nxt = WC_GAP;
        w_cnt_nxt   = '0;
      end
      WC_GAP: if (r_cnt == 8'(GAP_W - 1)) begin
        w_state_nxt = WC_IDLE;
        w_cnt_nxt   = '0;
        done        = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + 8'd1;
      end
      default: w_state_nxt = WC_IDLE;
    endcase
    if (abort) begin
      w_state_nxt = WC_IDLE;
      w_cnt_nxt   = '0;
      w_load      = 1'b0;
      done        = 1'b0;
    end
  end

  assign CS_bar = !(r_state == WC_SETUP || r_state == WC_PULSE || r_state == WC_HOLD);
  assign WR_bar = (r_state != WC_PULSE);
  assign D_oe   = !CS_bar;
  assign A0     = r_a0;
  assign D_out  = r_data;

endmodule

// File: rtl/pic_cpu_intack_master.sv
// CPU-side initiator for the 8259A: init writes, two-pulse INTA, EOI writes.
module pic_cpu_intack_master
  import pic_pkg::*;
#(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_init,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw3,
  input  logic [7:0] icw4,
  input  logic [7:0] ocw1,
  input  logic       eoi_req,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  input  logic       INT,
  input  logic [7:0] D_in,
  output logic [7:0] D_out,
  output logic       D_oe,
  output logic       CS_bar,
  output logic       WR_bar,
  output logic       A0,
  output logic       INTA_bar,
  output logic [7:0] vector,
  output logic       vector_valid,
  output logic       init_done,
  output logic       busy
);

  state_t     r_state, w_state_nxt;
  init_step_t r_step, w_step_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic       r_launch, w_launch_nxt;
  logic       r_init_done, w_done_set;
  logic       r_aeoi;
  logic [7:0] r_icw1, r_icw2, r_icw3, r_icw4, r_ocw1;
  logic       r_eoi_pend, r_eoi_spec;
  logic [2:0] r_eoi_lvl;
  logic [7:0] r_eoi_byte, w_eoi_byte_nxt;
  logic [7:0] r_vector;
  logic       r_vv, w_capture, w_take_req;
  logic       r_int_meta, r_int_s;
  logic       w_req_now, w_req_any;
  logic [7:0] w_req_byte;
  logic       w_wr_a0, w_wr_done;
  logic [7:0] w_wr_data;

  // Two-flop synchronizer for the asynchronous INT line
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_int_meta <= 1'b0;
      r_int_s    <= 1'b0;
    end else begin
      r_int_meta <= INT;
      r_int_s    <= r_int_meta;
    end
  end

  // Configuration bytes captured on start_init
  always_ff @(posedge clk) begin
    if (start_init) begin
      r_icw1 <= icw1;
      r_icw2 <= icw2;
      r_icw3 <= icw3;
      r_icw4 <= icw4;
      r_ocw1 <= ocw1;
    end
  end

  // One-deep EOI request latch; a newer request overwrites an older one
  always_ff @(posedge clk) begin
    if (!rst_n || start_init) begin
      r_eoi_pend <= 1'b0;
      r_eoi_spec <= 1'b0;
      r_eoi_lvl  <= '0;
    end else if (w_take_req) begin
      r_eoi_pend <= 1'b0;
    end else if (w_req_now) begin
      r_eoi_pend <= 1'b1;
      r_eoi_spec <= eoi_specific;
      r_eoi_lvl  <= eoi_level;
    end
  end

  assign w_req_now  = eoi_req && r_init_done;
  assign w_req_any  = w_req_now || r_eoi_pend;
  assign w_req_byte = w_req_now ? ocw2_eoi(eoi_specific, eoi_level) : ocw2_eoi(r_eoi_spec, r_eoi_lvl);

  // Main FSM state register and its companion control registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_step      <= STEP_ICW1;
      r_cnt       <= '0;
      r_launch    <= 1'b0;
      r_init_done <= 1'b0;
      r_aeoi      <= 1'b0;
      r_eoi_byte  <= NS_EOI;
      r_vector    <= '0;
      r_vv        <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_step     <= w_step_nxt;
      r_cnt      <= w_cnt_nxt;
      r_launch   <= w_launch_nxt;
      r_eoi_byte <= w_eoi_byte_nxt;
      r_vv       <= w_capture;
      if (start_init)      r_init_done <= 1'b0;
      else if (w_done_set) r_init_done <= 1'b1;
      if (start_init)      r_aeoi <= icw1[ICW1_IC4] & icw4[ICW4_AEOI];
      if (w_capture)       r_vector <= D_in;
    end
  end

  // Next-state logic; start_init overrides everything below it
  always_comb begin
    w_state_nxt    = r_state;
    w_step_nxt     = r_step;
    w_cnt_nxt      = r_cnt;
    w_launch_nxt   = 1'b0;
    w_done_set     = 1'b0;
    w_capture      = 1'b0;
    w_take_req     = 1'b0;
    w_eoi_byte_nxt = r_eoi_byte;
    case (r_state)
      ST_INIT_WR: if (w_wr_done) begin
        if (r_step == STEP_OCW1) begin
          w_state_nxt = ST_READY;
          w_done_set  = 1'b1;
        end else begin
          w_step_nxt   = next_step(r_step, r_icw1[ICW1_SNGL], r_icw1[ICW1_IC4]);
          w_launch_nxt = 1'b1;
        end
      end
      ST_READY: if (w_req_any) begin
        w_state_nxt    = ST_EOI_WR;
        w_eoi_byte_nxt = w_req_byte;
        w_take_req     = 1'b1;
        w_launch_nxt   = 1'b1;
      end else if (r_int_s) begin
        w_state_nxt = ST_ACK1;
        w_cnt_nxt   = '0;
      end
      ST_ACK1: if (r_cnt == 8'(PULSE_W - 1)) begin
        w_state_nxt = ST_ACK_GAP;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = r_cnt + 8'd1;
      end
      ST_ACK_GAP: if (r_cnt == 8'(GAP_W - 1)) begin
        w_state_nxt = ST_ACK2;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = r_cnt + 8'd1;
      end
      ST_ACK2: if (r_cnt == 8'(PULSE_W - 1)) begin
        w_capture = 1'b1;
        w_cnt_nxt = '0;
        if (w_req_any) begin
          w_state_nxt    = ST_EOI_WR;
          w_eoi_byte_nxt = w_req_byte;
          w_take_req     = 1'b1;
          w_launch_nxt   = 1'b1;
        end else if (!r_aeoi) begin
          w_state_nxt    = ST_EOI_WR;
          w_eoi_byte_nxt = NS_EOI;
          w_launch_nxt   = 1'b1;
        end else begin
          w_state_nxt = ST_READY;
        end
      end else begin
        w_cnt_nxt = r_cnt + 8'd1;
      end
      ST_EOI_WR: if (w_wr_done) w_state_nxt = ST_READY;
      default: w_state_nxt = r_state;
    endcase
    if (start_init) begin
      w_state_nxt  = ST_INIT_WR;
      w_step_nxt   = STEP_ICW1;
      w_cnt_nxt    = '0;
      w_launch_nxt = 1'b1;
      w_done_set   = 1'b0;
      w_capture    = 1'b0;
      w_take_req   = 1'b0;
    end
  end

  // Address/data offered to the write engine for the current init word or EOI
  always_comb begin
    w_wr_a0   = 1'b0;
    w_wr_data = r_eoi_byte;
    if (r_state == ST_INIT_WR) begin
      w_wr_a0 = (r_step != STEP_ICW1);
      case (r_step)
        STEP_ICW1: w_wr_data = r_icw1;
        STEP_ICW2: w_wr_data = r_icw2;
        STEP_ICW3: w_wr_data = r_icw3;
        STEP_ICW4: w_wr_data = r_icw4;
        default:   w_wr_data = r_ocw1;
      endcase
    end
  end

  pic_bus_write_cycle #(.PULSE_W(PULSE_W), .GAP_W(GAP_W)) u_wr (
    .clk    (clk),
    .rst_n  (rst_n),
    .abort  (start_init),
    .start  (r_launch),
    .a0     (w_wr_a0),
    .data   (w_wr_data),
    .CS_bar (CS_bar),
    .WR_bar (WR_bar),
    .A0     (A0),
    .D_out  (D_out),
    .D_oe   (D_oe),
    .done   (w_wr_done)
  );

  assign INTA_bar     = !(r_state == ST_ACK1 || r_state == ST_ACK2);
  assign busy         = !(r_state == ST_IDLE || r_state == ST_READY);
  assign vector       = r_vector;
  assign vector_valid = r_vv;
  assign init_done    = r_init_done;

endmodule

// File: tb/tb_pic_cpu_intack_master.sv
// Directed bench: bus monitor plus transaction-level model of the initiator.
module tb_pic_cpu_intack_master;

  localparam int PULSE_W = 2;
  localparam int GAP_W   = 2;

  logic       clk = 1'b0;
  logic       rst_n, start_init, eoi_req, eoi_specific, INT;
  logic [7:0] icw1, icw2, icw3, icw4, ocw1;
  logic [2:0] eoi_level;
  logic [7:0] D_in, D_out, vector;
  logic       D_oe, CS_bar, WR_bar, A0, INTA_bar, vector_valid, init_done, busy;

  logic [7:0] pic_vec;
  int         pulses_done;

  int n_chk  = 0;
  int n_fail = 0;

  logic [8:0] obs_wr[$];
  logic [8:0] exp_wr[$];
  int         q_plen[$];
  int         q_gap[$];
  logic [7:0] q_vec[$];
  logic       q_busyvv[$];
  logic       m_aeoi;

  always #5 clk = ~clk;

  // The PIC puts its vector on the bus only during the second INTA pulse
  assign D_in = (!INTA_bar && pulses_done == 1) ? pic_vec : 8'hFF;

  pic_cpu_intack_master #(.PULSE_W(PULSE_W), .GAP_W(GAP_W)) dut (
    .clk(clk), .rst_n(rst_n), .start_init(start_init),
    .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4), .ocw1(ocw1),
    .eoi_req(eoi_req), .eoi_specific(eoi_specific), .eoi_level(eoi_level),
    .INT(INT), .D_in(D_in), .D_out(D_out), .D_oe(D_oe),
    .CS_bar(CS_bar), .WR_bar(WR_bar), .A0(A0), .INTA_bar(INTA_bar),
    .vector(vector), .vector_valid(vector_valid), .init_done(init_done), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Expected write list of an init sequence, from the ICW1 SNGL/IC4 rules
  task automatic model_init(input logic [7:0] i1, i2, i3, i4, o1);
    exp_wr.delete();
    exp_wr.push_back({1'b0, i1});
    exp_wr.push_back({1'b1, i2});
    if (!i1[1]) exp_wr.push_back({1'b1, i3});
    if (i1[0])  exp_wr.push_back({1'b1, i4});
    exp_wr.push_back({1'b1, o1});
    m_aeoi = i1[0] & i4[1];
  endtask

  task automatic check_writes(input string nm);
    chk({nm, "_count"}, obs_wr.size(), exp_wr.size());
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++)
      chk({nm, "_word"}, obs_wr[i], exp_wr[i]);
  endtask

  // Bus monitor: per-cycle protocol rules plus transaction capture
  logic       prev_cs, prev_inta;
  int         cs_len, wr_len, cs_high, inta_len, inta_high;
  logic [8:0] wr_lat;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_cs = 1'b1; prev_inta = 1'b1; cs_len = 0; wr_len = 0; cs_high = 100;
      inta_len = 0; inta_high = 0; pulses_done = 0; wr_lat = '0;
    end else begin
      chk("doe_vs_cs", D_oe, !CS_bar);
      if (!WR_bar)  chk("wr_inside_cs", CS_bar, 1'b0);
      if (!INTA_bar) chk("inta_needs_init", init_done, 1'b1);
      if (!CS_bar || !INTA_bar) chk("busy_on_bus", busy, 1'b1);
      if (!CS_bar) begin
        if (prev_cs) begin
          chk("wr_gap_min", cs_high >= GAP_W, 1'b1);
          chk("wr_setup", WR_bar, 1'b1);
          wr_lat = {A0, D_out}; cs_len = 1; wr_len = 0;
        end else begin
          chk("wr_addr_data_stable", {A0, D_out}, wr_lat);
          cs_len++;
        end
        if (!WR_bar) wr_len++;
      end else begin
        if (!prev_cs) begin
          chk("wr_pulse_len", wr_len, PULSE_W);
          chk("wr_cycle_len", cs_len, PULSE_W + 2);
          obs_wr.push_back(wr_lat);
          cs_high = 1;
        end else cs_high++;
      end
      if (vector_valid) begin
        chk("vv_after_inta_rise", (!prev_inta && INTA_bar), 1'b1);
        q_vec.push_back(vector);
        q_busyvv.push_back(busy);
      end
      if (!INTA_bar) begin
        if (prev_inta) begin
          if (pulses_done == 1) q_gap.push_back(inta_high);
          inta_len = 1;
        end else inta_len++;
      end else begin
        if (!prev_inta) begin
          q_plen.push_back(inta_len);
          pulses_done = pulses_done ^ 1;
          inta_high = 1;
        end else inta_high++;
      end
      prev_cs = CS_bar;
      prev_inta = INTA_bar;
    end
  end

  task automatic start_cfg(input logic [7:0] i1, i2, i3, i4, o1);
    @(posedge clk); #1;
    icw1 = i1; icw2 = i2; icw3 = i3; icw4 = i4; ocw1 = o1;
    start_init = 1'b1;
    obs_wr.delete();
    model_init(i1, i2, i3, i4, o1);
    @(posedge clk); #1;
    start_init = 1'b0;
  endtask

  task automatic wait_init(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (init_done) ok = 1'b1;
    end
    if (!ok) expire(nm);
  endtask

  task automatic wait_inta_low(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (!INTA_bar) ok = 1'b1;
    end
    if (!ok) expire(nm);
  endtask

  task automatic wait_vec_and_idle(input string nm, input int n0);
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (q_vec.size() > n0) ok = 1'b1;
    end
    if (!ok) expire({nm, "_vector"});
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    if (!ok) expire({nm, "_idle"});
    repeat (6) @(negedge clk);
  endtask

  task automatic clear_obs();
    obs_wr.delete(); exp_wr.delete(); q_plen.delete(); q_gap.delete();
  endtask

  // Full acknowledge with the PIC dropping INT once the first INTA is seen
  task automatic do_ack(input string nm, input logic [7:0] vec);
    int n0;
    clear_obs();
    pic_vec = vec;
    n0 = q_vec.size();
    INT = 1'b1;
    wait_inta_low({nm, "_inta"});
    INT = 1'b0;
    wait_vec_and_idle(nm, n0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    bit ok;
    rst_n = 1'b0; start_init = 1'b0; eoi_req = 1'b0; eoi_specific = 1'b0; eoi_level = '0;
    INT = 1'b0; pic_vec = '0; m_aeoi = 1'b0;
    icw1 = '0; icw2 = '0; icw3 = '0; icw4 = '0; ocw1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_CS_bar", CS_bar, 1'b1);
    chk("rst_WR_bar", WR_bar, 1'b1);
    chk("rst_INTA_bar", INTA_bar, 1'b1);
    chk("rst_A0", A0, 1'b0);
    chk("rst_D_out", D_out, 8'h00);
    chk("rst_D_oe", D_oe, 1'b0);
    chk("rst_vector", vector, 8'h00);
    chk("rst_vector_valid", vector_valid, 1'b0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // EOI request before initialization must be dropped
    @(posedge clk); #1; eoi_req = 1'b1;
    @(posedge clk); #1; eoi_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_cs", CS_bar, 1'b1);

    // 1: single mode, IC4=1
    start_cfg(8'h13, 8'h08, 8'h55, 8'h01, 8'h00);
    wait_init("t1_init");
    check_writes("t1");
    chk("t1_lit_n", obs_wr.size(), 4);
    if (obs_wr.size() == 4) begin
      chk("t1_lit_w0", obs_wr[0], 9'h013);
      chk("t1_lit_w1", obs_wr[1], 9'h108);
      chk("t1_lit_w2", obs_wr[2], 9'h101);
      chk("t1_lit_w3", obs_wr[3], 9'h100);
    end
    repeat (20) @(negedge clk);
    chk("t1_no_stray_eoi", obs_wr.size(), 4);
    chk("t1_ready_busy", busy, 1'b0);

    // 2: cascade mode, ICW3 sent
    start_cfg(8'h11, 8'h08, 8'h04, 8'h01, 8'h00);
    wait_init("t2_init");
    check_writes("t2");
    chk("t2_lit_n", obs_wr.size(), 5);
    if (obs_wr.size() == 5) chk("t2_lit_icw3", obs_wr[2], 9'h104);

    // 3: acknowledge, AEOI=0 -> non-specific EOI
    do_ack("t3", 8'h0B);
    exp_wr.push_back({1'b0, 8'h20});
    check_writes("t3");
    if (obs_wr.size() == 1) chk("t3_lit_eoi", obs_wr[0], 9'h020);
    chk("t3_npulses", q_plen.size(), 2);
    if (q_plen.size() == 2) begin
      chk("t3_pulse1", q_plen[0], PULSE_W);
      chk("t3_pulse2", q_plen[1], PULSE_W);
    end
    chk("t3_ngap", q_gap.size(), 1);
    if (q_gap.size() == 1) chk("t3_gap", q_gap[0], GAP_W);
    chk("t3_vector", q_vec[q_vec.size()-1], 8'h0B);
    chk("t3_busy_at_vv", q_busyvv[q_busyvv.size()-1], 1'b1);

    // 4: AEOI mode -> no EOI write, READY right after ACK2
    start_cfg(8'h13, 8'h08, 8'h00, 8'h03, 8'h00);
    wait_init("t4_init");
    check_writes("t4_init");
    chk("t4_model_aeoi", m_aeoi, 1'b1);
    do_ack("t4", 8'h47);
    check_writes("t4");
    chk("t4_npulses", q_plen.size(), 2);
    chk("t4_vector", q_vec[q_vec.size()-1], 8'h47);
    chk("t4_busy_at_vv", q_busyvv[q_busyvv.size()-1], 1'b0);

    // 5: specific EOI requested during ACK1 replaces the automatic one
    start_cfg(8'h13, 8'h08, 8'h00, 8'h01, 8'h00);
    wait_init("t5_init");
    clear_obs();
    pic_vec = 8'h21;
    n0 = q_vec.size();
    INT = 1'b1;
    wait_inta_low("t5_inta");
    INT = 1'b0;
    @(posedge clk); #1; eoi_req = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd3;
    @(posedge clk); #1; eoi_req = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0;
    wait_vec_and_idle("t5", n0);
    exp_wr.push_back({1'b0, 8'h63});
    check_writes("t5");
    if (obs_wr.size() == 1) chk("t5_lit_eoi", obs_wr[0], 9'h063);
    chk("t5_npulses", q_plen.size(), 2);
    chk("t5_vector", q_vec[q_vec.size()-1], 8'h21);

    // 6: start_init during the second INTA pulse
    clear_obs();
    pic_vec = 8'h5A;
    n0 = q_vec.size();
    INT = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (!INTA_bar) INT = 1'b0;
      if (!INTA_bar && pulses_done == 1) ok = 1'b1;
    end
    if (!ok) expire("t6_ack2");
    icw1 = 8'h13; icw2 = 8'h08; icw3 = 8'h00; icw4 = 8'h01; ocw1 = 8'h00;
    start_init = 1'b1;
    model_init(8'h13, 8'h08, 8'h00, 8'h01, 8'h00);
    @(posedge clk); #1;
    start_init = 1'b0;
    @(negedge clk);
    chk("t6_inta_released", INTA_bar, 1'b1);
    chk("t6_init_done_clr", init_done, 1'b0);
    chk("t6_vector_kept", vector, 8'h21);
    chk("t6_cs_released", CS_bar, 1'b1);
    INT = 1'b1;
    wait_init("t6_init");
    check_writes("t6");
    if (obs_wr.size() > 0) chk("t6_lit_icw1", obs_wr[0], 9'h013);
    chk("t6_no_vv", q_vec.size(), n0);
    chk("t6_npulses", q_plen.size(), 2);
    if (q_plen.size() == 2) chk("t6_cut_pulse", q_plen[1], 1);
    wait_inta_low("t6_reack");
    INT = 1'b0;
    wait_vec_and_idle("t6", n0);
    chk("t6_vector_new", vector, 8'h5A);
    chk("t6_nwrites", obs_wr.size(), 5);
    if (obs_wr.size() == 5) chk("t6_eoi", obs_wr[4], 9'h020);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
